gol_generation_scheduler: RTL and testbench

Sequencing controller for the Game of Life datapath: it gates the board set-up phase, paces the generation engine at a programmable rate, and supports free-run, pause and single-step. It issues one start pulse per generation and waits for the engine's done. It keeps the generation count and returns the machine to set-up on request. It sits between the debounced button pulses and the init/set-up/algorithm engines, replacing ad-hoc one-hot state enables.

---
 rtl/gol_generation_scheduler_if.sv | 50 +++++
 rtl/gol_generation_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_gol_generation_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gol_generation_scheduler_if.sv
// ---------------------------------------------------------------------------
// gol_generation_scheduler_if
//   Handshake bundle between the button/engine side and the Game of Life
//   generation scheduler.
//
//   Requests (master -> slave):
//     setup_done    one-cycle pulse, board entry finished
//     run_req       one-cycle pulse, toggle run/pause
//     step_req      one-cycle pulse, compute exactly one generation
//     clear_req     one-cycle pulse, abandon run and return to set-up
//     alg_done      one-cycle pulse from engine, generation committed
//     board_changed engine flag valid with alg_done, new board differs
//   Status (slave -> master):
//     init_start    one-cycle pulse, re-initialise board and counts
//     setup_en      level, set-up editor may write the board
//     alg_start     one-cycle pulse, engine computes next generation
//     running       high while free-running
//     halted        high when stopped on a still life
//     state         encoded scheduler state
//     gen_cnt       generations completed since last init
//
//   Modports: master (request source / engine side), slave (scheduler).
// ---------------------------------------------------------------------------
interface gol_generation_scheduler_if #(
  parameter int unsigned GEN_W = 16
);
  logic             setup_done;
  logic             run_req;
  logic             step_req;
  logic             clear_req;
  logic             alg_done;
  logic             board_changed;
  logic             init_start;
  logic             setup_en;
  logic             alg_start;
  logic             running;
  logic             halted;
  logic [2:0]       state;
  logic [GEN_W-1:0] gen_cnt;

  modport master (
    output setup_done, run_req, step_req, clear_req, alg_done, board_changed,
    input  init_start, setup_en, alg_start, running, halted, state, gen_cnt
  );

  modport slave (
    input  setup_done, run_req, step_req, clear_req, alg_done, board_changed,
    output init_start, setup_en, alg_start, running, halted, state, gen_cnt
  );
endinterface

// File: rtl/gol_generation_scheduler.sv
// ---------------------------------------------------------------------------
// gol_generation_scheduler
//   Sequencing controller for the Game of Life datapath. Gates the board
//   set-up phase, paces the generation engine at TICK_DIV clock cycles per
//   generation in free-run, and supports pause and single-step. One
//   alg_start pulse is issued per generation and the engine's alg_done is
//   always awaited (a clear request arriving mid-generation is deferred).
//
//   Parameters:
//     TICK_DIV  ClkPort cycles spent waiting between generations (>= 2)
//     GEN_W     generation counter width
//
//   Ports:
//     ClkPort   system clock, rising edge
//     reset_n   asynchronous active-low reset
//     bus       gol_generation_scheduler_if.slave (requests in, status out)
//
//   Optional feature:
//     GOL_AUTO_HALT_EN  when defined, a committed generation that left the
//                       board unchanged moves the scheduler to HALTED.
//                       When undefined, board_changed is ignored and halted
//                       is tied low.
// ---------------------------------------------------------------------------
module gol_generation_scheduler #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                         ClkPort,
  input  logic                         reset_n,
  gol_generation_scheduler_if.slave    bus
);

  localparam int unsigned   TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_SETUP     = 3'd1,
    S_PAUSED    = 3'd2,
    S_RUN_WAIT  = 3'd3,
    S_RUN_BUSY  = 3'd4,
    S_STEP_BUSY = 3'd5,
    S_HALTED    = 3'd6
  } state_t;

  state_t           state_q,      state_d;
  logic [TW-1:0]    tick_q,       tick_d;
  logic [GEN_W-1:0] gen_q,        gen_d;
  logic             pause_pend_q, pause_pend_d;
  logic             clear_pend_q, clear_pend_d;
  logic             init_start_q, init_start_d;
  logic             alg_start_q,  alg_start_d;
  logic             halt_on_done;
  logic             clear_now;
  logic [GEN_W-1:0] gen_next;

`ifdef GOL_AUTO_HALT_EN
  assign halt_on_done = ~bus.board_changed;
`else
  logic unused_board_changed;
  assign halt_on_done         = 1'b0;
  assign unused_board_changed = bus.board_changed;
`endif

  // Saturating generation increment.
  assign gen_next = (gen_q == '1) ? gen_q : gen_q + 1'b1;

  // A clear seen now or earlier in the current busy phase.
  assign clear_now = bus.clear_req | clear_pend_q;

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      tick_q       <= '0;
      gen_q        <= '0;
      pause_pend_q <= 1'b0;
      clear_pend_q <= 1'b0;
      init_start_q <= 1'b0;
      alg_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      gen_q        <= gen_d;
      pause_pend_q <= pause_pend_d;
      clear_pend_q <= clear_pend_d;
      init_start_q <= init_start_d;
      alg_start_q  <= alg_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    gen_d        = gen_q;
    pause_pend_d = pause_pend_q;
    clear_pend_d = clear_pend_q;
    init_start_d = 1'b0;
    alg_start_d  = 1'b0;

    unique case (state_q)
      // INIT is entered with init_start already registered high, except
      // straight out of reset where the pulse is still owed: hold INIT one
      // extra cycle to issue it, so the engine is always re-initialised.
      S_INIT: begin
        gen_d        = '0;
        tick_d       = '0;
        pause_pend_d = 1'b0;
        clear_pend_d = 1'b0;
        if (init_start_q) begin
          state_d = S_SETUP;
        end else begin
          init_start_d = 1'b1;
        end
      end

      S_SETUP: begin
        if (bus.clear_req) begin
          state_d      = S_INIT;
          init_start_d = 1'b1;
          gen_d        = '0;
        end else if (bus.setup_done) begin
          state_d = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (bus.clear_req) begin
          state_d      = S_INIT;
          init_start_d = 1'b1;
          gen_d        = '0;
        end else if (bus.run_req) begin
          state_d = S_RUN_WAIT;
          tick_d  = '0;
        end else if (bus.step_req) begin
          state_d     = S_STEP_BUSY;
          alg_start_d = 1'b1;
        end
      end

      S_RUN_WAIT: begin
        if (bus.clear_req) begin
          state_d      = S_INIT;
          init_start_d = 1'b1;
          gen_d        = '0;
          tick_d       = '0;
        end else if (bus.run_req) begin
          state_d = S_PAUSED;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          state_d     = S_RUN_BUSY;
          alg_start_d = 1'b1;
          tick_d      = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_RUN_BUSY: begin
        clear_pend_d = clear_now;
        if (bus.run_req) begin
          pause_pend_d = ~pause_pend_q;
        end
        if (bus.alg_done) begin
          clear_pend_d = 1'b0;
          pause_pend_d = 1'b0;
          tick_d       = '0;
          if (clear_now) begin
            state_d      = S_INIT;
            init_start_d = 1'b1;
            gen_d        = '0;
          end else begin
            gen_d = gen_next;
            if (halt_on_done) begin
              state_d = S_HALTED;
            end else if (pause_pend_q ^ bus.run_req) begin
              state_d = S_PAUSED;
            end else begin
              state_d = S_RUN_WAIT;
            end
          end
        end
      end

      S_STEP_BUSY: begin
        clear_pend_d = clear_now;
        if (bus.alg_done) begin
          clear_pend_d = 1'b0;
          if (clear_now) begin
            state_d      = S_INIT;
            init_start_d = 1'b1;
            gen_d        = '0;
          end else begin
            gen_d   = gen_next;
            state_d = halt_on_done ? S_HALTED : S_PAUSED;
          end
        end
      end

      S_HALTED: begin
        if (bus.clear_req) begin
          state_d      = S_INIT;
          init_start_d = 1'b1;
          gen_d        = '0;
        end
      end

      default: begin
        state_d      = S_INIT;
        init_start_d = 1'b1;
        gen_d        = '0;
        tick_d       = '0;
        pause_pend_d = 1'b0;
        clear_pend_d = 1'b0;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.gen_cnt    = gen_q;
  assign bus.init_start = init_start_q;
  assign bus.alg_start  = alg_start_q;
  assign bus.setup_en   = (state_q == S_SETUP);
  assign bus.running    = (state_q == S_RUN_WAIT) || (state_q == S_RUN_BUSY);
`ifdef GOL_AUTO_HALT_EN
  assign bus.halted     = (state_q == S_HALTED);
`else
  assign bus.halted     = 1'b0;
`endif

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gol_generation_scheduler
//   Directed bench for gol_generation_scheduler with TICK_DIV=4. Expected
//   generation counts are queued when alg_done is driven and compared when
//   the scheduler commits them.
// ---------------------------------------------------------------------------
module tb_gol_generation_scheduler;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned GEN_W    = 16;

  logic ClkPort = 1'b0;
  logic reset_n = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned exp_q[$];

  gol_generation_scheduler_if #(.GEN_W(GEN_W)) dut_if ();

  gol_generation_scheduler #(
    .TICK_DIV (TICK_DIV),
    .GEN_W    (GEN_W)
  ) dut (
    .ClkPort (ClkPort),
    .reset_n (reset_n),
    .bus     (dut_if)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic tick();
    @(posedge ClkPort);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until alg_start is seen (bounded); returns the cycle it was seen.
  task automatic wait_start(input string tag, input int unsigned budget, output int unsigned at);
    int unsigned n = 0;
    while (dut_if.alg_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, dut_if.alg_start}, 32'd1);
    at = cyc;
  endtask

  // Engine commits one generation: pulse alg_done, then check the count.
  task automatic engine_done(input string tag, input logic changed, input int unsigned expect_gen);
    dut_if.alg_done      = 1'b1;
    dut_if.board_changed = changed;
    exp_q.push_back(expect_gen);
    tick();
    dut_if.alg_done      = 1'b0;
    dut_if.board_changed = 1'b1;
    chk(tag, dut_if.gen_cnt, exp_q.pop_front());
  endtask

  initial begin
    int unsigned at, prev, p, n;

    dut_if.setup_done    = 1'b0;
    dut_if.run_req       = 1'b0;
    dut_if.step_req      = 1'b0;
    dut_if.clear_req     = 1'b0;
    dut_if.alg_done      = 1'b0;
    dut_if.board_changed = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_state",      dut_if.state, 0);
    chk("rst_init_start", {31'd0, dut_if.init_start}, 0);
    chk("rst_alg_start",  {31'd0, dut_if.alg_start}, 0);
    chk("rst_setup_en",   {31'd0, dut_if.setup_en}, 0);
    chk("rst_running",    {31'd0, dut_if.running}, 0);
    chk("rst_halted",     {31'd0, dut_if.halted}, 0);
    chk("rst_gen_cnt",    dut_if.gen_cnt, 0);

    // Release, init pulse at cycle 1, set-up cycles 2..5, PAUSED at 6
    reset_n = 1'b1;
    cyc = 0;
    tick();
    chk("c1_init_start", {31'd0, dut_if.init_start}, 1);
    chk("c1_state",      dut_if.state, 0);
    tick();
    chk("c2_init_start", {31'd0, dut_if.init_start}, 0);
    chk("c2_state",      dut_if.state, 1);
    chk("c2_setup_en",   {31'd0, dut_if.setup_en}, 1);
    tick();
    tick();
    tick();
    chk("c5_setup_en",   {31'd0, dut_if.setup_en}, 1);
    dut_if.setup_done = 1'b1;
    tick();
    dut_if.setup_done = 1'b0;
    chk("c6_state",      dut_if.state, 2);
    chk("c6_setup_en",   {31'd0, dut_if.setup_en}, 0);

    // run_req + step_req together: run wins, no immediate start
    dut_if.run_req  = 1'b1;
    dut_if.step_req = 1'b1;
    p = cyc;
    tick();
    dut_if.run_req  = 1'b0;
    dut_if.step_req = 1'b0;
    chk("runstep_state", dut_if.state, 3);
    chk("runstep_nostart", {31'd0, dut_if.alg_start}, 0);
    chk("runstep_running", {31'd0, dut_if.running}, 1);
    wait_start("first_start", 10, at);
    chk("first_start_lat", at - p, 5);

    // Free-run, engine latency 3 -> start every 8 cycles
    for (int unsigned g = 1; g <= 3; g++) begin
      chk("fr_busy_state", dut_if.state, 4);
      chk("fr_busy_running", {31'd0, dut_if.running}, 1);
      tick();
      tick();
      tick();
      engine_done("fr_gen_cnt", 1'b1, g);
      chk("fr_wait_state", dut_if.state, 3);
      chk("fr_wait_running", {31'd0, dut_if.running}, 1);
      prev = at;
      wait_start("fr_start", 12, at);
      chk("fr_period", at - prev, 8);
    end

    // Pause requested during RUN_BUSY takes effect at alg_done
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    chk("pp_still_busy", dut_if.state, 4);
    tick();
    tick();
    engine_done("pp_gen_cnt", 1'b1, 4);
    chk("pp_state", dut_if.state, 2);
    chk("pp_running", {31'd0, dut_if.running}, 0);
    n = 0;
    repeat (20) begin
      tick();
      if (dut_if.alg_start === 1'b1) n++;
    end
    chk("pp_no_start", n, 0);

    // run_req at terminal tick count: pause wins, no start
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    tick();
    tick();
    tick();
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    chk("tc_state", dut_if.state, 2);
    chk("tc_nostart", {31'd0, dut_if.alg_start}, 0);

    // Single step
    dut_if.step_req = 1'b1;
    tick();
    dut_if.step_req = 1'b0;
    chk("st_start", {31'd0, dut_if.alg_start}, 1);
    chk("st_state", dut_if.state, 5);
    tick();
    chk("st_start_once", {31'd0, dut_if.alg_start}, 0);
    engine_done("st_gen_cnt", 1'b1, 5);
    chk("st_back_paused", dut_if.state, 2);

    // Clear during STEP_BUSY waits for alg_done, then INIT
    dut_if.step_req = 1'b1;
    tick();
    dut_if.step_req  = 1'b0;
    dut_if.clear_req = 1'b1;
    tick();
    dut_if.clear_req = 1'b0;
    chk("cl_still_busy", dut_if.state, 5);
    tick();
    engine_done("cl_gen_cnt", 1'b1, 0);
    chk("cl_state_init", dut_if.state, 0);
    chk("cl_init_start", {31'd0, dut_if.init_start}, 1);
    tick();
    chk("cl_state_setup", dut_if.state, 1);
    chk("cl_init_once", {31'd0, dut_if.init_start}, 0);

    // Unchanged board after a generation
    dut_if.setup_done = 1'b1;
    tick();
    dut_if.setup_done = 1'b0;
    chk("ah_paused", dut_if.state, 2);
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    wait_start("ah_start", 10, at);
    tick();
    tick();
    tick();
    engine_done("ah_gen_cnt", 1'b0, 1);
`ifdef GOL_AUTO_HALT_EN
    chk("ah_state", dut_if.state, 6);
    chk("ah_halted", {31'd0, dut_if.halted}, 1);
    chk("ah_running", {31'd0, dut_if.running}, 0);
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    chk("ah_run_ignored", dut_if.state, 6);
`else
    chk("ah_state", dut_if.state, 3);
    chk("ah_halted", {31'd0, dut_if.halted}, 0);
    chk("ah_running", {31'd0, dut_if.running}, 1);
    dut_if.run_req = 1'b1;
    tick();
    dut_if.run_req = 1'b0;
    chk("ah_run_pauses", dut_if.state, 2);
`endif
    dut_if.clear_req = 1'b1;
    tick();
    dut_if.clear_req = 1'b0;
    chk("ah_clear_state", dut_if.state, 0);
    chk("ah_clear_init", {31'd0, dut_if.init_start}, 1);
    chk("ah_clear_gen", dut_if.gen_cnt, 0);
    tick();
    chk("ah_clear_setup", dut_if.state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
